timer_ctrl: RTL and testbench
=============================

TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 The block SHALL have exactly one clock and one reset, as follows: clk, input, 1 bit, clock; all state updates on the rising edge.
REQ-002 reset  input  1  SHALL be asynchronous and active-high; asserting it forces reset state immediately, independent of clk.
REQ-003 addr  input  32  SHALL be the byte address of the data-bus access.
REQ-004 wdata  input  32  SHALL be the store data.
REQ-005 mem_write  input  1  SHALL be the store strobe, sampled at the clk edge.
REQ-006 mem_read  input  1  SHALL be the load strobe.
REQ-007 rdata  output  32  SHALL be the load data; combinational from addr and mem_read.
REQ-008 hit  output  1  SHALL be combinational, high when addr matches any block register, for the bus read mux.
REQ-009 irq  output  1  SHALL be the registered interrupt request to the CPU.

Function
REQ-010 The register map SHALL be: TH 0x40000000 (reload, R/W); TL 0x40000004 (count, R/W); TCON 0x40000008 (bits 2:0, R/W); SYSTICK 0x40000024 (R only).
REQ-011 The TCON bits SHALL be: bit0 = count enable; bit1 = interrupt enable; bit2 = interrupt flag.
REQ-012 Addresses other than the four in REQ-010 SHALL be ignored: hit=0, rdata=0, and writes have no effect.
REQ-013 Reads of TCON SHALL return {29'b0, TCON[2:0]}, and rdata SHALL be 0 whenever mem_read=0.
REQ-014 When TCON[0]=1 and TL≠0xFFFFFFFF at an edge, TL SHALL increment by 1, using 32-bit unsigned arithmetic.
REQ-015 When TCON[0]=1 and TL=0xFFFFFFFF at an edge (overflow), TL SHALL load TH on that edge.
REQ-016 On an overflow edge with TCON[1]=1, the same edge SHALL set TCON[2]; with TCON[1]=0, the flag is unchanged.
REQ-017 When TCON[0]=0, TL SHALL hold its value.
REQ-018 Each edge SHALL use the TCON value registered before that edge; a TCON write affects counting from the following edge.
REQ-019 irq SHALL be registered as TCON[1]&TCON[2] using the post-edge TCON values, so that irq is valid the same cycle as the flag.
REQ-020 irq SHALL stay high until software clears TCON[2] or TCON[1].
REQ-021 A TL write coinciding with an increment or overflow SHALL win: TL=wdata.
REQ-022 A TH write coinciding with an overflow SHALL leave TL reloading the old TH, while TH takes the new value.
REQ-023 A TCON write coinciding with an overflow that sets the flag SHALL load TCON[1:0] from wdata and set TCON[2]=1, regardless of wdata[2] (set wins, so no interrupt is lost).
REQ-024 SYSTICK SHALL increment every edge, wrap from 0xFFFFFFFF to 0, and ignore writes.
REQ-025 A simultaneous mem_read and mem_write to the same register SHALL return the pre-edge value on rdata.

Reset
REQ-026 While reset=1, the block SHALL hold TH=0, TL=0, TCON=0, SYSTICK=0 and irq=0.
REQ-027 While reset=1, rdata and hit SHALL still decode combinationally.
REQ-028 Reset asserted mid-count or while irq=1 SHALL clear all state at once, and after release counting SHALL stay stopped until TCON[0] is written to 1.

Verification
REQ-029 Scenario: write TH=TL=0xFFFFFC18, then TCON=3 at edge 0 -> TL=0xFFFFFFFF after edge 999; after edge 1000 TL=0xFFFFFC18, TCON=7 and irq=1; irq then repeats every 1000 cycles.
REQ-030 Scenario: with irq=1, store TCON = TCON & 0xFFFFFFF9 -> after that edge TCON=1 and irq=0; TL continues counting; a later store of TCON|2 restores interrupts on the next overflow.
REQ-031 Scenario: TL=0xFFFFFFFF, TCON=3, and a TCON write of 0x3 on the overflow edge -> TCON=7 and irq=1 (set wins); on the same edge, a TL write of 0x5 -> TL=5.
REQ-032 Scenario: TCON=1 (interrupt disabled), run through overflow -> TL reloads TH, TCON stays 1, irq stays 0.
REQ-033 Scenario: assert reset asynchronously between edges while TL=0x1234 and irq=1 -> TL, TH, TCON, SYSTICK and irq are 0 before the next edge; 10 edges after release, TL=0 and SYSTICK=10.
REQ-034 Scenario: read 0x4000000C and 0x40000024 with a write to 0x40000024 -> for 0x4000000C, hit=0 and rdata=0; SYSTICK is unaffected by the write and still reads the running count.

Source files
------------

// File: rtl/timer_ctrl.sv
// ---------------------------------------------------------------------------
// timer_ctrl
//
// Memory-mapped interval timer with a free-running system tick counter.
// Software programs a reload value (TH), a running count (TL) and a small
// control/status register (TCON). When counting is enabled, TL counts up
// once per clock. When TL reaches all-ones, the next edge reloads it from TH.
// If interrupts are enabled, that same edge also sets the interrupt flag.
// SYSTICK counts every clock and is read-only.
//
// Register map (byte addresses):
//    0x40000000  TH       reload value, R/W
//    0x40000004  TL       running count, R/W
//    0x40000008  TCON     [0] count enable, [1] irq enable, [2] irq flag
//    0x40000024  SYSTICK  free-running cycle count, read-only
//
// Ports:
//    clk        clock, all state updates on the rising edge
//    reset      asynchronous active-high reset
//    addr       byte address of the bus access
//    wdata      store data
//    mem_write  store strobe, sampled at the clock edge
//    mem_read   load strobe
//    rdata      load data, combinational, zero when not reading or no hit
//    hit        combinational, high when addr selects one of our registers
//    irq        registered interrupt request (TCON[1] & TCON[2])
// ---------------------------------------------------------------------------
module timer_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        mem_write,
   input  logic        mem_read,
   output logic [31:0] rdata,
   output logic        hit,
   output logic        irq
);

   localparam logic [31:0] ADDR_TH      = 32'h4000_0000;
   localparam logic [31:0] ADDR_TL      = 32'h4000_0004;
   localparam logic [31:0] ADDR_TCON    = 32'h4000_0008;
   localparam logic [31:0] ADDR_SYSTICK = 32'h4000_0024;
   localparam logic [31:0] ALL_ONES     = 32'hFFFF_FFFF;

   logic [31:0] th_q, th_d;
   logic [31:0] tl_q, tl_d;
   logic [2:0]  tcon_q, tcon_d;
   logic [31:0] systick_q, systick_d;
   logic        irq_q, irq_d;

   logic selTh, selTl, selTcon, selSystick;
   logic wrTh, wrTl, wrTcon;
   logic countEn, overflow;

   // Full 32-bit address decode. Any other address falls outside the block.
   always_comb begin
      selTh      = (addr == ADDR_TH);
      selTl      = (addr == ADDR_TL);
      selTcon    = (addr == ADDR_TCON);
      selSystick = (addr == ADDR_SYSTICK);
      hit        = selTh | selTl | selTcon | selSystick;
   end

   // SYSTICK has no write strobe, so stores to it are dropped here.
   always_comb begin
      wrTh   = mem_write & selTh;
      wrTl   = mem_write & selTl;
      wrTcon = mem_write & selTcon;
   end

   // The count step and the overflow test both use the registered TCON.
   // A TCON store therefore only affects counting from the following edge.
   always_comb begin
      countEn  = tcon_q[0];
      overflow = countEn & (tl_q == ALL_ONES);
   end

   // Read mux. It shows the current register contents, so a store and a
   // load to the same register in one cycle return the pre-edge value.
   always_comb begin
      rdata = 32'h0;
      if (mem_read) begin
         if (selTh) begin
            rdata = th_q;
         end else if (selTl) begin
            rdata = tl_q;
         end else if (selTcon) begin
            rdata = {29'b0, tcon_q};
         end else if (selSystick) begin
            rdata = systick_q;
         end
      end
   end

   // TL next state. A software store takes priority over counting. On an
   // overflow edge the reload uses the TH value held before that edge, so
   // a TH store on the same edge only affects later reloads.
   always_comb begin
      tl_d = tl_q;
      if (wrTl) begin
         tl_d = wdata;
      end else if (overflow) begin
         tl_d = th_q;
      end else if (countEn) begin
         tl_d = tl_q + 32'd1;
      end
   end

   // TH is a plain software register.
   always_comb begin
      th_d = th_q;
      if (wrTh) begin
         th_d = wdata;
      end
   end

   // TCON next state. Software may rewrite all three bits. When an overflow
   // with interrupts enabled lands on the same edge as a store, the flag is
   // still set, so an interrupt is never lost to a racing store.
   always_comb begin
      tcon_d = tcon_q;
      if (wrTcon) begin
         tcon_d = wdata[2:0];
      end
      if (overflow && tcon_q[1]) begin
         tcon_d[2] = 1'b1;
      end
   end

   // irq is computed from the post-edge TCON. This keeps it aligned with
   // the flag in the same cycle, instead of trailing it by one clock.
   always_comb begin
      irq_d     = tcon_d[1] & tcon_d[2];
      systick_d = systick_q + 32'd1;
   end

   // State registers. Reset clears everything immediately. Counting then
   // stays stopped until software sets the enable bit again.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         th_q      <= 32'h0;
         tl_q      <= 32'h0;
         tcon_q    <= 3'b000;
         systick_q <= 32'h0;
         irq_q     <= 1'b0;
      end else begin
         th_q      <= th_d;
         tl_q      <= tl_d;
         tcon_q    <= tcon_d;
         systick_q <= systick_d;
         irq_q     <= irq_d;
      end
   end

   assign irq = irq_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_timer_ctrl
//
// Testbench for timer_ctrl. A reference model of the programmer-visible
// registers is advanced once per clock edge. The model applies the
// register-level rules directly: count, reload, flag set, store priority.
// Each scenario task checks the DUT against that model, or against
// hand-derived constants.
// ---------------------------------------------------------------------------
module tb_timer_ctrl;

   localparam logic [31:0] ADDR_TH      = 32'h4000_0000;
   localparam logic [31:0] ADDR_TL      = 32'h4000_0004;
   localparam logic [31:0] ADDR_TCON    = 32'h4000_0008;
   localparam logic [31:0] ADDR_SYSTICK = 32'h4000_0024;
   localparam logic [31:0] ADDR_HOLE    = 32'h4000_000C;

   logic        clk;
   logic        reset;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        mem_write;
   logic        mem_read;
   logic [31:0] rdata;
   logic        hit;
   logic        irq;

   int checks;
   int errors;

   // Reference model of the software-visible state
   logic [31:0] mTh;
   logic [31:0] mTl;
   logic [2:0]  mTcon;
   logic [31:0] mSys;
   logic        mIrq;

   timer_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .addr      (addr),
      .wdata     (wdata),
      .mem_write (mem_write),
      .mem_read  (mem_read),
      .rdata     (rdata),
      .hit       (hit),
      .irq       (irq)
   );

   // Free-running clock with a 20-unit period
   initial clk = 1'b0;
   always #10 clk = ~clk;

   function automatic logic [31:0] modelRead(input logic [31:0] a);
      if (a == ADDR_TH)      return mTh;
      if (a == ADDR_TL)      return mTl;
      if (a == ADDR_TCON)    return {29'b0, mTcon};
      if (a == ADDR_SYSTICK) return mSys;
      return 32'h0;
   endfunction

   function automatic logic modelHit(input logic [31:0] a);
      return (a == ADDR_TH) || (a == ADDR_TL) || (a == ADDR_TCON) || (a == ADDR_SYSTICK);
   endfunction

   task automatic modelReset();
      mTh   = 32'h0;
      mTl   = 32'h0;
      mTcon = 3'b000;
      mSys  = 32'h0;
      mIrq  = 1'b0;
   endtask

   // One clock edge of the model, driven by the current bus inputs
   task automatic modelStep();
      logic        ovf;
      logic [31:0] nTl;
      logic [31:0] nTh;
      logic [2:0]  nTcon;
      ovf   = mTcon[0] && (mTl == 32'hFFFF_FFFF);
      nTl   = mTl;
      nTh   = mTh;
      nTcon = mTcon;
      if (mTcon[0]) nTl = ovf ? mTh : mTl + 32'd1;
      if (mem_write && addr == ADDR_TL)   nTl = wdata;
      if (mem_write && addr == ADDR_TH)   nTh = wdata;
      if (mem_write && addr == ADDR_TCON) nTcon = wdata[2:0];
      if (ovf && mTcon[1]) nTcon[2] = 1'b1;
      mTl   = nTl;
      mTh   = nTh;
      mTcon = nTcon;
      mSys  = mSys + 32'd1;
      mIrq  = nTcon[1] & nTcon[2];
   endtask

   // Advance one edge and land on the following falling edge
   task automatic step();
      @(posedge clk);
      modelStep();
      @(negedge clk);
   endtask

   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d,
                                input logic w, input logic r);
      addr      = a;
      wdata     = d;
      mem_write = w;
      mem_read  = r;
   endtask

   task automatic busWrite(input logic [31:0] a, input logic [31:0] d);
      applyStimulus(a, d, 1'b1, 1'b0);
      step();
      mem_write = 1'b0;
   endtask

   task automatic checkOutput(input logic [31:0] a, input string name);
      applyStimulus(a, 32'h0, 1'b0, 1'b1);
      #1;
      checks++;
      if (rdata !== modelRead(a)) begin
         errors++;
         $display("[TB] FAIL %s rdata: got %h expected %h", name, rdata, modelRead(a));
      end
      checks++;
      if (hit !== modelHit(a)) begin
         errors++;
         $display("[TB] FAIL %s hit: got %b expected %b", name, hit, modelHit(a));
      end
   endtask

   task automatic checkState(input string name);
      checkOutput(ADDR_TH, {name, ".TH"});
      checkOutput(ADDR_TL, {name, ".TL"});
      checkOutput(ADDR_TCON, {name, ".TCON"});
      checkOutput(ADDR_SYSTICK, {name, ".SYSTICK"});
      checks++;
      if (irq !== mIrq) begin
         errors++;
         $display("[TB] FAIL %s irq: got %b expected %b", name, irq, mIrq);
      end
   endtask

   // Read one register and compare it with a hand-derived constant
   task automatic checkConst(input logic [31:0] a, input logic [31:0] exp, input string name);
      applyStimulus(a, 32'h0, 1'b0, 1'b1);
      #1;
      checks++;
      if (rdata !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, rdata, exp);
      end
   endtask

   task automatic checkIrq(input logic exp, input string name);
      checks++;
      if (irq !== exp) begin
         errors++;
         $display("[TB] FAIL %s irq: got %b expected %b", name, irq, exp);
      end
   endtask

   // State while reset is held. Decode must still work during reset.
   task automatic test_reset();
      checkConst(ADDR_TH, 32'h0, "reset.TH");
      checkConst(ADDR_TL, 32'h0, "reset.TL");
      checkConst(ADDR_TCON, 32'h0, "reset.TCON");
      checkConst(ADDR_SYSTICK, 32'h0, "reset.SYSTICK");
      checkIrq(1'b0, "reset");
      checks++;
      if (hit !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset.hit: got %b expected 1", hit);
      end
      #2;
      reset = 1'b0;
      modelReset();
      step();
      checkState("after_reset");
   endtask

   // Reload period of 1000 cycles, followed by flag clear and re-enable
   task automatic test_reload();
      int n;
      busWrite(ADDR_TH, 32'hFFFF_FC18);
      busWrite(ADDR_TL, 32'hFFFF_FC18);
      busWrite(ADDR_TCON, 32'h3);
      for (int i = 0; i < 999; i++) step();
      checkConst(ADDR_TL, 32'hFFFF_FFFF, "reload.edge999.TL");
      checkIrq(1'b0, "reload.edge999");
      step();
      checkConst(ADDR_TL, 32'hFFFF_FC18, "reload.edge1000.TL");
      checkConst(ADDR_TCON, 32'h7, "reload.edge1000.TCON");
      checkIrq(1'b1, "reload.edge1000");
      checkState("reload.model");
      busWrite(ADDR_TCON, 32'h7 & 32'hFFFF_FFF9);
      checkConst(ADDR_TCON, 32'h1, "clear.TCON");
      checkConst(ADDR_TL, 32'hFFFF_FC19, "clear.TL");
      checkIrq(1'b0, "clear");
      busWrite(ADDR_TCON, 32'h1 | 32'h2);
      n = 0;
      while (irq !== 1'b1 && n < 1100) begin
         step();
         n++;
      end
      checks++;
      if (n != 998) begin
         errors++;
         $display("[TB] FAIL reenable.cycles: got %0d expected 998", n);
      end
      checkState("reenable");
   endtask

   // Races between stores and the overflow edge
   task automatic test_back_to_back();
      busWrite(ADDR_TCON, 32'h0);
      busWrite(ADDR_TH, 32'h100);
      busWrite(ADDR_TL, 32'hFFFF_FFFF);
      busWrite(ADDR_TCON, 32'h3);
      busWrite(ADDR_TCON, 32'h3);
      checkConst(ADDR_TCON, 32'h7, "setwins.TCON");
      checkConst(ADDR_TL, 32'h100, "setwins.TL");
      checkIrq(1'b1, "setwins");

      busWrite(ADDR_TCON, 32'h0);
      busWrite(ADDR_TL, 32'hFFFF_FFFF);
      busWrite(ADDR_TCON, 32'h3);
      busWrite(ADDR_TL, 32'h5);
      checkConst(ADDR_TL, 32'h5, "tlwins.TL");
      checkConst(ADDR_TCON, 32'h7, "tlwins.TCON");

      busWrite(ADDR_TCON, 32'h0);
      busWrite(ADDR_TL, 32'hFFFF_FFFF);
      busWrite(ADDR_TCON, 32'h1);
      busWrite(ADDR_TH, 32'h200);
      checkConst(ADDR_TL, 32'h100, "threload.TL");
      checkConst(ADDR_TH, 32'h200, "threload.TH");
      checkState("back_to_back");
   endtask

   // Overflow with interrupts disabled
   task automatic test_no_irq();
      busWrite(ADDR_TCON, 32'h0);
      busWrite(ADDR_TH, 32'hABCD);
      busWrite(ADDR_TL, 32'hFFFF_FFFE);
      busWrite(ADDR_TCON, 32'h1);
      step();
      checkConst(ADDR_TL, 32'hFFFF_FFFF, "noirq.pre.TL");
      step();
      checkConst(ADDR_TL, 32'hABCD, "noirq.TL");
      checkConst(ADDR_TCON, 32'h1, "noirq.TCON");
      checkIrq(1'b0, "noirq");
   endtask

   // Asynchronous reset while irq is high
   task automatic test_async_reset();
      busWrite(ADDR_TCON, 32'h6);
      busWrite(ADDR_TL, 32'h1234);
      checkConst(ADDR_TL, 32'h1234, "areset.pre.TL");
      checkIrq(1'b1, "areset.pre");
      #2;
      reset = 1'b1;
      #1;
      modelReset();
      checkConst(ADDR_TL, 32'h0, "areset.TL");
      checkConst(ADDR_TH, 32'h0, "areset.TH");
      checkConst(ADDR_TCON, 32'h0, "areset.TCON");
      checkConst(ADDR_SYSTICK, 32'h0, "areset.SYSTICK");
      checkIrq(1'b0, "areset");
      @(posedge clk);
      @(negedge clk);
      #2;
      reset = 1'b0;
      for (int i = 0; i < 10; i++) step();
      checkConst(ADDR_TL, 32'h0, "areset.post.TL");
      checkConst(ADDR_SYSTICK, 32'd10, "areset.post.SYSTICK");
      checkState("areset.post");
   endtask

   // Unmapped hole and write attempts to SYSTICK
   task automatic test_decode();
      applyStimulus(ADDR_HOLE, 32'hDEAD_BEEF, 1'b1, 1'b1);
      #1;
      checks++;
      if (hit !== 1'b0 || rdata !== 32'h0) begin
         errors++;
         $display("[TB] FAIL hole: got hit=%b rdata=%h expected hit=0 rdata=0", hit, rdata);
      end
      step();
      applyStimulus(ADDR_SYSTICK, 32'h0, 1'b1, 1'b1);
      #1;
      checks++;
      if (rdata !== mSys) begin
         errors++;
         $display("[TB] FAIL systick.rw: got %h expected %h", rdata, mSys);
      end
      step();
      mem_write = 1'b0;
      checkState("decode");
   endtask

   // Random bus traffic, with TL writes biased toward the overflow point
   task automatic test_random();
      logic [31:0] a;
      logic [31:0] d;
      logic        w;
      logic        r;
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 5))
            0: a = ADDR_TH;
            1: a = ADDR_TL;
            2: a = ADDR_TCON;
            3: a = ADDR_SYSTICK;
            4: a = ADDR_HOLE;
            default: a = 32'h5000_0000 | ($urandom & 32'hFFFC);
         endcase
         d = $urandom;
         if (a == ADDR_TL) d = 32'hFFFF_FFF0 + $urandom_range(0, 15);
         if (a == ADDR_TH) d = $urandom_range(0, 3) == 0 ? 32'hFFFF_FFF8 : d;
         w = ($urandom_range(0, 3) == 0);
         r = ($urandom_range(0, 1) == 1);
         applyStimulus(a, d, w, r);
         #1;
         checks++;
         if (rdata !== (r ? modelRead(a) : 32'h0)) begin
            errors++;
            $display("[TB] FAIL random[%0d] rdata @%h: got %h expected %h",
                     i, a, rdata, r ? modelRead(a) : 32'h0);
         end
         checks++;
         if (hit !== modelHit(a)) begin
            errors++;
            $display("[TB] FAIL random[%0d] hit @%h: got %b expected %b", i, a, hit, modelHit(a));
         end
         step();
         checks++;
         if (irq !== mIrq) begin
            errors++;
            $display("[TB] FAIL random[%0d] irq: got %b expected %b", i, irq, mIrq);
         end
      end
      mem_write = 1'b0;
      checkState("random.end");
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      applyStimulus(32'h0, 32'h0, 1'b0, 1'b0);
      modelReset();
      @(negedge clk);
      $display("[TB] starting timer_ctrl tests");
      test_reset();
      test_reload();
      test_back_to_back();
      test_no_irq();
      test_async_reset();
      test_decode();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Hard stop so that a stuck scenario still ends the run
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
